// File: rtl/counter_sched.sv
// counter_sched -- run controller and trigger scheduler for the counter timebase.
//
// Gates the counter through its active-low enable and turns its per-bit
// trigger pulses into events on NCH channels. Each channel watches one
// trig_in bit (its tap). Pending events go to a single consumer over a
// valid/ready handshake, one at a time, with round-robin arbitration.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, stop         single-cycle run / stop requests
//   cnt_n_en            counter enable, active low (0 only while running)
//   trig_in[WIDTH]      trigger pulses from the counter
//   cfg_we/ch/tap/en    per-channel configuration write
//   evt_valid/ch/ready  event handshake towards the consumer
//   busy                high whenever the controller is not idle
//   ovf[NCH], ovf_clr   sticky per-channel overflow and its clear
//                       (only when COUNTER_SCHED_OVF_EN is defined)
//
// Optional feature macro: COUNTER_SCHED_OVF_EN
module counter_sched #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int TAPW  = $clog2(WIDTH),
   parameter int CHW   = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   output logic             cnt_n_en,
   input  logic [WIDTH-1:0] trig_in,
   input  logic             cfg_we,
   input  logic [CHW-1:0]   cfg_ch,
   input  logic [TAPW-1:0]  cfg_tap,
   input  logic             cfg_en,
   output logic             evt_valid,
   output logic [CHW-1:0]   evt_ch,
   input  logic             evt_ready,
`ifdef COUNTER_SCHED_OVF_EN
   output logic [NCH-1:0]   ovf,
   input  logic             ovf_clr,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t          r_state;
   logic            r_n_en;
   logic            r_busy;
   logic [NCH-1:0]  r_pend;
   logic [NCH-1:0]  r_en;
   logic [TAPW-1:0] r_tap [NCH];
   logic [CHW-1:0]  r_rr_ptr;
   logic            r_valid;
   logic [CHW-1:0]  r_ch;

   logic            w_hs;
   logic [NCH-1:0]  w_fire;
   logic [NCH-1:0]  w_hs_mask;
   logic [NCH-1:0]  w_dis_mask;
   logic [NCH-1:0]  w_cand;
   logic [NCH-1:0]  w_pend_nxt;
   logic [CHW-1:0]  w_next_ptr;
   logic [CHW-1:0]  w_base;
   logic [CHW-1:0]  w_win;
   logic            w_win_vld;

   // Channel after ch, wrapping modulo NCH (NCH need not be a power of two).
   function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] ch);
      if (ch == CHW'(NCH - 1)) return '0;
      return ch + 1'b1;
   endfunction

   // First candidate at or after base, wrapping. Scanning from the far end
   // lets the closest match overwrite the others. MSB of result = found.
   function automatic logic [CHW:0] rr_pick(input logic [NCH-1:0] cand,
                                            input logic [CHW-1:0] base);
      logic [CHW:0] res;
      int           idx;
      res = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = (int'(base) + k) % NCH;
         if (cand[idx]) res = {1'b1, CHW'(idx)};
      end
      return res;
   endfunction

   always_comb begin
      w_hs       = r_valid & evt_ready;
      w_fire     = '0;
      w_hs_mask  = '0;
      w_dis_mask = '0;
      for (int c = 0; c < NCH; c++) begin
         if (w_hs && r_ch == CHW'(c)) w_hs_mask[c] = 1'b1;
         if (cfg_we && !cfg_en && cfg_ch == CHW'(c)) w_dis_mask[c] = 1'b1;
         if (r_state == S_RUN && r_en[c] && trig_in[r_tap[c]]) w_fire[c] = 1'b1;
      end
      // A trigger landing on the channel being handed off keeps it pending.
      w_pend_nxt = ((r_pend & ~w_hs_mask) | w_fire) & ~w_dis_mask;
      // Fresh triggers only become visible to the arbiter one edge later.
      w_cand     = r_pend & ~w_hs_mask & ~w_dis_mask;
      w_next_ptr = next_ch(r_ch);
      w_base     = w_hs ? w_next_ptr : r_rr_ptr;
      {w_win_vld, w_win} = rr_pick(w_cand, w_base);
   end

   // Run-control FSM with registered counter enable and busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_n_en  <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !stop) begin
                  r_state <= S_RUN;
                  r_n_en  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (stop) begin
                  r_state <= S_DRAIN;
                  r_n_en  <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_pend == '0 && !r_valid) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_n_en  <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Pending set, configuration and the presented event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend   <= '0;
         r_en     <= '0;
         r_rr_ptr <= '0;
         r_valid  <= 1'b0;
         r_ch     <= '0;
         for (int c = 0; c < NCH; c++) r_tap[c] <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         // Matching by channel number drops writes to out-of-range channels.
         for (int c = 0; c < NCH; c++) begin
            if (cfg_we && cfg_ch == CHW'(c)) begin
               r_tap[c] <= cfg_tap;
               r_en[c]  <= cfg_en;
            end
         end
         if (w_hs) r_rr_ptr <= w_next_ptr;
         // Only reload when nothing is presented or it is being taken, so a
         // stalled event never changes channel.
         if (!r_valid || w_hs) begin
            r_valid <= w_win_vld;
            if (w_win_vld) r_ch <= w_win;
         end
      end
   end

`ifdef COUNTER_SCHED_OVF_EN
   logic [NCH-1:0] r_ovf;

   // A re-trigger of a channel still pending and not handed off this edge
   // is lost; record it. A new overflow beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_ovf <= '0;
      else     r_ovf <= (ovf_clr ? '0 : r_ovf) | (w_fire & r_pend & ~w_hs_mask);
   end

   assign ovf = r_ovf;
`endif

   assign cnt_n_en  = r_n_en;
   assign busy      = r_busy;
   assign evt_valid = r_valid;
   assign evt_ch    = r_ch;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus a randomized run checked
// against a behavioural model of the scheduler.
module tb_counter_sched;

   localparam int WIDTH = 8;
   localparam int NCH   = 4;
   localparam int TAPW  = $clog2(WIDTH);
   localparam int CHW   = $clog2(NCH);

   logic             clk = 1'b0;
   logic             rst;
   logic             start, stop;
   logic             cnt_n_en;
   logic [WIDTH-1:0] trig_in;
   logic             cfg_we;
   logic [CHW-1:0]   cfg_ch;
   logic [TAPW-1:0]  cfg_tap;
   logic             cfg_en;
   logic             evt_valid;
   logic [CHW-1:0]   evt_ch;
   logic             evt_ready;
   logic             busy;
   logic             ovf_clr;
`ifdef COUNTER_SCHED_OVF_EN
   logic [NCH-1:0]   ovf;
`endif

   int total = 0;
   int bad   = 0;

   counter_sched #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cnt_n_en(cnt_n_en),
      .trig_in(trig_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_tap(cfg_tap),
      .cfg_en(cfg_en), .evt_valid(evt_valid), .evt_ch(evt_ch),
      .evt_ready(evt_ready),
`ifdef COUNTER_SCHED_OVF_EN
      .ovf(ovf), .ovf_clr(ovf_clr),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int           m_state;   // 0 idle, 1 run, 2 drain
   bit           m_pend [NCH];
   bit           m_en   [NCH];
   int           m_tap  [NCH];
   bit           m_valid;
   int           m_ch;
   int           m_rr;
   bit           m_nen;
   bit [NCH-1:0] m_ovf;

   task automatic model_reset();
      m_state = 0; m_valid = 0; m_ch = 0; m_rr = 0; m_nen = 1; m_ovf = '0;
      for (int c = 0; c < NCH; c++) begin
         m_pend[c] = 0; m_en[c] = 0; m_tap[c] = 0;
      end
   endtask

   task automatic model_edge();
      bit hs, any_pend;
      bit fire [NCH];
      int base, win, nst, idx;
      if (rst) begin
         model_reset();
         return;
      end
      hs = m_valid && evt_ready;
      any_pend = 0;
      for (int c = 0; c < NCH; c++) begin
         fire[c] = (m_state == 1) && m_en[c] && trig_in[m_tap[c]];
         if (m_pend[c]) any_pend = 1;
      end
      base = hs ? (m_ch + 1) % NCH : m_rr;
      win = -1;
      for (int k = 0; k < NCH; k++) begin
         idx = (base + k) % NCH;
         if (win < 0 && m_pend[idx] && !(hs && idx == m_ch) &&
             !(cfg_we && !cfg_en && int'(cfg_ch) == idx))
            win = idx;
      end
      nst = m_state;
      if (m_state == 0 && start && !stop) nst = 1;
      else if (m_state == 1 && stop) nst = 2;
      else if (m_state == 2 && !any_pend && !m_valid) nst = 0;
      for (int c = 0; c < NCH; c++) begin
         if (ovf_clr) m_ovf[c] = 0;
         if (fire[c] && m_pend[c] && !(hs && m_ch == c)) m_ovf[c] = 1;
         if (hs && m_ch == c) m_pend[c] = 0;
         if (fire[c]) m_pend[c] = 1;
         if (cfg_we && !cfg_en && int'(cfg_ch) == c) m_pend[c] = 0;
      end
      if (hs) m_rr = (m_ch + 1) % NCH;
      if (!m_valid || hs) begin
         m_valid = (win >= 0);
         if (win >= 0) m_ch = win;
      end
      if (cfg_we) begin
         m_tap[cfg_ch] = int'(cfg_tap);
         m_en[cfg_ch]  = cfg_en;
      end
      m_state = nst;
      m_nen   = (nst != 1);
   endtask

   // One clock: model follows the edge, then return at the falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic cfg(input int ch, input int tap, input bit en);
      cfg_we = 1; cfg_ch = CHW'(ch); cfg_tap = TAPW'(tap); cfg_en = en;
      tick();
      cfg_we = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      total++; if (cnt_n_en !== 1'b1) begin bad++; $display("FAIL reset_n_en got=%b want=1", cnt_n_en); end
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", evt_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef COUNTER_SCHED_OVF_EN
      total++; if (ovf !== '0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
      rst = 0;
      cfg(0, 0, 1);
      trig_in = '1;
      tick();
      trig_in = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL idle_trig_ignored cyc=%0d got=%b want=0", i, evt_valid); end
      end
   endtask

   task automatic test_dispatch();
      cfg(1, 1, 1);
      start = 1; tick(); start = 0;
      total++; if (cnt_n_en !== 1'b0) begin bad++; $display("FAIL start_n_en got=%b want=0", cnt_n_en); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", busy); end
      trig_in = 8'b11; tick(); trig_in = '0;
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL disp_latency got=%b want=0", evt_valid); end
      evt_ready = 1;
      tick();
      total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin bad++; $display("FAIL disp_first got=%b/%0d want=1/0", evt_valid, evt_ch); end
      tick();
      total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin bad++; $display("FAIL disp_second got=%b/%0d want=1/1", evt_valid, evt_ch); end
      tick();
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL disp_done got=%b want=0", evt_valid); end
      evt_ready = 0;
   endtask

   task automatic test_backpressure();
      evt_ready = 0;
      trig_in = 8'b01; tick(); trig_in = '0;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0d want=1/0", i, evt_valid, evt_ch); end
      end
      trig_in = 8'b01; tick(); trig_in = '0;
`ifdef COUNTER_SCHED_OVF_EN
      total++; if (ovf !== 4'b0001) begin bad++; $display("FAIL bp_ovf_set got=%b want=0001", ovf); end
      ovf_clr = 1; tick(); ovf_clr = 0;
      total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL bp_ovf_clr got=%b want=0000", ovf); end
`endif
      evt_ready = 1; tick();
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bp_merged got=%b want=0", evt_valid); end
      tick();
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bp_merged2 got=%b want=0", evt_valid); end
      evt_ready = 0;
   endtask

   // Trigger period of 5: the fourth grant's handshake lands on the fifth
   // edge, so the next pulse coincides with it rather than overflowing.
   task automatic test_fairness();
      int grants[$];
      int exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      do_reset();
      for (int c = 0; c < NCH; c++) cfg(c, 0, 1);
      start = 1; tick(); start = 0;
      evt_ready = 1;
      for (int cyc = 0; cyc < 13; cyc++) begin
         trig_in = (cyc == 0 || cyc == 5) ? 8'b01 : 8'b00;
         if (evt_valid && evt_ready) grants.push_back(int'(evt_ch));
         tick();
      end
      trig_in = '0;
      total++; if (grants.size() != 8) begin bad++; $display("FAIL fair_count got=%0d want=8", grants.size()); end
      for (int i = 0; i < 8 && i < grants.size(); i++) begin
         total++; if (grants[i] != exp_g[i]) begin bad++; $display("FAIL fair_order idx=%0d got=%0d want=%0d", i, grants[i], exp_g[i]); end
      end
`ifdef COUNTER_SCHED_OVF_EN
      total++; if (ovf !== '0) begin bad++; $display("FAIL fair_ovf got=%b want=0", ovf); end
`endif
   endtask

   task automatic test_drain();
      int hs;
      cfg(3, 0, 0);
      evt_ready = 0;
      trig_in = 8'b01; tick(); trig_in = '0;
      tick();
      stop = 1; tick(); stop = 0;
      total++; if (cnt_n_en !== 1'b1) begin bad++; $display("FAIL drain_n_en got=%b want=1", cnt_n_en); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy got=%b want=1", busy); end
      evt_ready = 1;
      hs = 0;
      for (int i = 0; i < 20 && hs < 3; i++) begin
         if (evt_valid) begin
            total++; if (int'(evt_ch) != hs) begin bad++; $display("FAIL drain_order got=%0d want=%0d", evt_ch, hs); end
            hs++;
         end
         tick();
      end
      total++; if (hs != 3) begin bad++; $display("FAIL drain_events got=%0d want=3", hs); end
      total++; if (busy !== 1'b1 || evt_valid !== 1'b0) begin bad++; $display("FAIL drain_last got busy/valid=%b/%b want=1/0", busy, evt_valid); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b want=0", busy); end
      evt_ready = 0;
   endtask

   task automatic test_async_reset();
      start = 1; tick(); start = 0;
      trig_in = 8'b01; tick(); trig_in = '0;
      tick();
      total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL ares_pre got=%b want=1", evt_valid); end
      #2 rst = 1;
      model_reset();
      #1;
      total++; if (evt_valid !== 1'b0 || cnt_n_en !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ares_now got v/n/b=%b/%b/%b want=0/1/0", evt_valid, cnt_n_en, busy); end
      #1 rst = 0;
      @(negedge clk);
      start = 1; tick(); start = 0;
      trig_in = '1; tick(); trig_in = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ares_disabled cyc=%0d got=%b want=0", i, evt_valid); end
      end
      stop = 1; tick(); stop = 0;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < NCH; c++) cfg(c, $urandom_range(0, WIDTH - 1), $urandom_range(0, 3) != 0);
      start = 1; tick(); start = 0;
      for (int cyc = 0; cyc < 430; cyc++) begin
         trig_in   = (cyc < 400) ? WIDTH'($urandom & $urandom) : '0;
         evt_ready = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
         ovf_clr   = ($urandom_range(0, 15) == 0);
         stop      = (cyc == 300);
         tick();
         total++; if (evt_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, evt_valid, m_valid); end
         if (m_valid) begin
            total++; if (int'(evt_ch) != m_ch) begin bad++; $display("FAIL rnd_ch cyc=%0d got=%0d want=%0d", cyc, evt_ch, m_ch); end
         end
         total++; if (busy !== (m_state != 0)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, m_state != 0); end
         total++; if (cnt_n_en !== m_nen) begin bad++; $display("FAIL rnd_n_en cyc=%0d got=%b want=%b", cyc, cnt_n_en, m_nen); end
`ifdef COUNTER_SCHED_OVF_EN
         total++; if (ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%b want=%b", cyc, ovf, m_ovf); end
`endif
      end
      stop = 0; ovf_clr = 0; evt_ready = 0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_final_idle got=%b want=0", busy); end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; start = 0; stop = 0; trig_in = '0; cfg_we = 0; cfg_ch = '0;
      cfg_tap = '0; cfg_en = 0; evt_ready = 0; ovf_clr = 0;
      model_reset();
      test_reset();
      test_dispatch();
      test_backpressure();
      test_fairness();
      test_drain();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
